// File: rtl/lce_ready_ctrl.sv
// LCE ready controller: outstanding-request credits plus blocked-cycle timeout, gating cache_req_ready_o.
// Define LCE_READY_CTRL_TIMEOUT_EN to build the timeout counter; otherwise timeout_o is tied low.
module lce_ready_ctrl #(
    parameter int credits_p           = 8,
    parameter int timeout_max_limit_p = 4
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             req_ready_i,
    input  logic                             cmd_ready_i,
    input  logic                             lce_req_v_i,
    input  logic                             lce_req_ready_i,
    input  logic                             cache_req_complete_i,
    input  logic                             uc_store_req_complete_i,
    input  logic                             data_mem_pkt_v_i,
    input  logic                             data_mem_pkt_yumi_i,
    input  logic                             tag_mem_pkt_v_i,
    input  logic                             tag_mem_pkt_yumi_i,
    input  logic                             stat_mem_pkt_v_i,
    input  logic                             stat_mem_pkt_yumi_i,
    output logic                             cache_req_ready_o,
    output logic                             credits_full_o,
    output logic                             credits_empty_o,
    output logic                             timeout_o,
    output logic [$clog2(credits_p+1)-1:0]   credit_count_o
);

    localparam int credit_width_lp = $clog2(credits_p + 1);
    localparam logic [credit_width_lp:0] credit_max_lp = (credit_width_lp + 1)'(credits_p);

    logic [credit_width_lp-1:0] credit_count_r;
    logic [credit_width_lp-1:0] credit_count_next_s;
    logic [credit_width_lp:0]   credit_sum_s;
    logic [credit_width_lp:0]   credit_dec_s;
    logic [credit_width_lp:0]   credit_diff_s;
    logic                       credit_inc_s;
    logic                       timeout_s;

    assign credit_inc_s  = lce_req_v_i & lce_req_ready_i;
    assign credit_dec_s  = (credit_width_lp + 1)'(cache_req_complete_i)
                         + (credit_width_lp + 1)'(uc_store_req_complete_i);
    assign credit_sum_s  = {1'b0, credit_count_r} + (credit_width_lp + 1)'(credit_inc_s);
    assign credit_diff_s = credit_sum_s - credit_dec_s;

    // Next credit count, clamped to [0, credits_p] so illegal traffic cannot wrap it.
    always_comb begin
        credit_count_next_s = credit_count_r;
        if (credit_dec_s > credit_sum_s) begin
            credit_count_next_s = {credit_width_lp{1'b0}};
        end else if (credit_diff_s > credit_max_lp) begin
            credit_count_next_s = credit_max_lp[credit_width_lp-1:0];
        end else begin
            credit_count_next_s = credit_diff_s[credit_width_lp-1:0];
        end
    end

    // Outstanding-request counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            credit_count_r <= {credit_width_lp{1'b0}};
        end else begin
            credit_count_r <= credit_count_next_s;
        end
    end

`ifdef LCE_READY_CTRL_TIMEOUT_EN
    localparam int timeout_width_lp = $clog2(timeout_max_limit_p + 1);
    localparam logic [timeout_width_lp-1:0] timeout_max_lp = timeout_width_lp'(timeout_max_limit_p);

    logic [timeout_width_lp-1:0] timeout_count_r;
    logic [timeout_width_lp-1:0] timeout_count_next_s;
    logic                        blocked_s;

    assign blocked_s = (data_mem_pkt_v_i & ~data_mem_pkt_yumi_i)
                     | (tag_mem_pkt_v_i  & ~tag_mem_pkt_yumi_i)
                     | (stat_mem_pkt_v_i & ~stat_mem_pkt_yumi_i);

    // Consecutive blocked-cycle count; wraps rather than saturating so timeout pulses once.
    always_comb begin
        timeout_count_next_s = timeout_count_r;
        if (blocked_s) begin
            timeout_count_next_s = timeout_count_r + timeout_width_lp'(1);
        end else begin
            timeout_count_next_s = {timeout_width_lp{1'b0}};
        end
    end

    // Blocked-cycle counter register.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            timeout_count_r <= {timeout_width_lp{1'b0}};
        end else begin
            timeout_count_r <= timeout_count_next_s;
        end
    end

    assign timeout_s = (timeout_count_r == timeout_max_lp);
`else
    logic unused_mem_ports_s;

    assign unused_mem_ports_s = ^{data_mem_pkt_v_i, data_mem_pkt_yumi_i,
                                  tag_mem_pkt_v_i,  tag_mem_pkt_yumi_i,
                                  stat_mem_pkt_v_i, stat_mem_pkt_yumi_i};
    assign timeout_s = 1'b0;
`endif

    assign credit_count_o    = credit_count_r;
    assign credits_full_o    = (credit_count_r == credit_max_lp[credit_width_lp-1:0]);
    assign credits_empty_o   = (credit_count_r == {credit_width_lp{1'b0}});
    assign timeout_o         = timeout_s;
    // Reset term keeps ready low while held in reset even though counters already read idle.
    assign cache_req_ready_o = reset_n_i & req_ready_i & cmd_ready_i & ~credits_full_o & ~timeout_s;

endmodule

// File: tb/tb_lce_ready_ctrl.sv
// Scoreboard bench for lce_ready_ctrl: driver pushes expected outputs from an integer model, monitor compares.
module tb_lce_ready_ctrl;
    localparam int CRED = 8;
    localparam int TMAX = 4;
    localparam int CW   = $clog2(CRED + 1);
    localparam int TMOD = 1 << $clog2(TMAX + 1);

    typedef struct packed {
        logic rst_n, rr, cr, lv, lr, cc, uc, dv, dy, tv, ty, sv, sy;
    } stim_t;

    typedef struct packed {
        logic          rdy, full, empty, tmo;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk_i = 1'b0;
    logic reset_n_i, req_ready_i, cmd_ready_i, lce_req_v_i, lce_req_ready_i;
    logic cache_req_complete_i, uc_store_req_complete_i;
    logic data_mem_pkt_v_i, data_mem_pkt_yumi_i, tag_mem_pkt_v_i, tag_mem_pkt_yumi_i;
    logic stat_mem_pkt_v_i, stat_mem_pkt_yumi_i;
    logic cache_req_ready_o, credits_full_o, credits_empty_o, timeout_o;
    logic [CW-1:0] credit_count_o;

    int   tests = 0;
    int   fails = 0;
    int   outstanding = 0;
    int   run = 0;
    exp_t exp_q[$];
    exp_t e;
    stim_t s;

    lce_ready_ctrl #(.credits_p(CRED), .timeout_max_limit_p(TMAX)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .req_ready_i(req_ready_i), .cmd_ready_i(cmd_ready_i),
        .lce_req_v_i(lce_req_v_i), .lce_req_ready_i(lce_req_ready_i),
        .cache_req_complete_i(cache_req_complete_i),
        .uc_store_req_complete_i(uc_store_req_complete_i),
        .data_mem_pkt_v_i(data_mem_pkt_v_i), .data_mem_pkt_yumi_i(data_mem_pkt_yumi_i),
        .tag_mem_pkt_v_i(tag_mem_pkt_v_i), .tag_mem_pkt_yumi_i(tag_mem_pkt_yumi_i),
        .stat_mem_pkt_v_i(stat_mem_pkt_v_i), .stat_mem_pkt_yumi_i(stat_mem_pkt_yumi_i),
        .cache_req_ready_o(cache_req_ready_o), .credits_full_o(credits_full_o),
        .credits_empty_o(credits_empty_o), .timeout_o(timeout_o),
        .credit_count_o(credit_count_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic stim_t base();
        stim_t b;
        b       = '0;
        b.rst_n = 1'b1;
        b.rr    = 1'b1;
        b.cr    = 1'b1;
        return b;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // One cycle: drive stimulus, queue the expected outputs, then advance the model across the edge.
    task automatic step(input stim_t st);
        exp_t x;
        bit   tmo;
        #1;
        reset_n_i = st.rst_n; req_ready_i = st.rr; cmd_ready_i = st.cr;
        lce_req_v_i = st.lv; lce_req_ready_i = st.lr;
        cache_req_complete_i = st.cc; uc_store_req_complete_i = st.uc;
        data_mem_pkt_v_i = st.dv; data_mem_pkt_yumi_i = st.dy;
        tag_mem_pkt_v_i = st.tv; tag_mem_pkt_yumi_i = st.ty;
        stat_mem_pkt_v_i = st.sv; stat_mem_pkt_yumi_i = st.sy;
        if (!st.rst_n) begin
            outstanding = 0;
            run = 0;
        end
`ifdef LCE_READY_CTRL_TIMEOUT_EN
        tmo = ((run % TMOD) == TMAX);
`else
        tmo = 1'b0;
`endif
        x.cnt   = CW'(outstanding);
        x.full  = (outstanding == CRED);
        x.empty = (outstanding == 0);
        x.tmo   = tmo;
        x.rdy   = st.rst_n && st.rr && st.cr && !x.full && !tmo;
        exp_q.push_back(x);
        @(posedge clk_i);
        if (st.rst_n) begin
            outstanding = outstanding + int'(st.lv & st.lr) - int'(st.cc) - int'(st.uc);
            if (outstanding < 0) outstanding = 0;
            if (outstanding > CRED) outstanding = CRED;
            if ((st.dv && !st.dy) || (st.tv && !st.ty) || (st.sv && !st.sy)) run = run + 1;
            else run = 0;
        end
    endtask

    // Monitor: compares the DUT against each queued expectation mid-cycle.
    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cache_req_ready", int'(cache_req_ready_o), int'(e.rdy));
            chk("credits_full", int'(credits_full_o), int'(e.full));
            chk("credits_empty", int'(credits_empty_o), int'(e.empty));
            chk("timeout", int'(timeout_o), int'(e.tmo));
            chk("credit_count", int'(credit_count_o), int'(e.cnt));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s = base();
        s.rst_n = 1'b0;
        reset_n_i = 1'b0; req_ready_i = 1'b1; cmd_ready_i = 1'b1;
        lce_req_v_i = 1'b0; lce_req_ready_i = 1'b0;
        cache_req_complete_i = 1'b0; uc_store_req_complete_i = 1'b0;
        data_mem_pkt_v_i = 1'b0; data_mem_pkt_yumi_i = 1'b0;
        tag_mem_pkt_v_i = 1'b0; tag_mem_pkt_yumi_i = 1'b0;
        stat_mem_pkt_v_i = 1'b0; stat_mem_pkt_yumi_i = 1'b0;
        @(posedge clk_i);
        repeat (3) step(s);
        s = base(); repeat (2) step(s);
        // Fill all credits, then return one.
        s.lv = 1'b1; s.lr = 1'b1; repeat (CRED) step(s);
        s = base(); step(s);
        s.cc = 1'b1; step(s);
        s = base(); step(s);
        // 7 -> 3, then handshake with both completions from 3 -> 2.
        s.cc = 1'b1; s.uc = 1'b1; repeat (2) step(s);
        s.lv = 1'b1; s.lr = 1'b1; step(s);
        s = base(); step(s);
        s.cc = 1'b1; s.uc = 1'b1; repeat (2) step(s);
        s = base(); step(s);
        // Data port blocked six cycles.
        s.dv = 1'b1; repeat (6) step(s);
        s = base(); step(s);
        // Blocked three, one accept, blocked four.
        s.dv = 1'b1; repeat (3) step(s);
        s.dy = 1'b1; step(s);
        s.dy = 1'b0; repeat (4) step(s);
        s = base(); step(s);
        s.tv = 1'b1; repeat (10) step(s);
        s = base(); step(s);
        // Randomized traffic with fill/drain phases and occasional mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            bit fill;
            fill    = ((i / 64) % 2) == 0;
            s       = base();
            s.rst_n = ($urandom_range(0, 199) != 0);
            s.rr    = ($urandom_range(0, 7) != 0);
            s.cr    = ($urandom_range(0, 15) != 0);
            s.lv    = fill ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            s.lr    = ($urandom_range(0, 3) != 0);
            s.cc    = fill ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 0);
            s.uc    = fill ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) == 0);
            s.dv    = ($urandom_range(0, 3) != 0);
            s.dy    = ($urandom_range(0, 4) == 0);
            s.tv    = ($urandom_range(0, 3) == 0);
            s.ty    = ($urandom_range(0, 1) == 0);
            s.sv    = ($urandom_range(0, 3) == 0);
            s.sy    = ($urandom_range(0, 1) == 0);
            step(s);
        end
        s = base(); step(s);
        @(negedge clk_i);
        @(negedge clk_i);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
